piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Downstream neighbour of the 4-bit parallel-in/parallel-out register stage: takes the registered parallel word and shifts it out one bit per enabled cycle.
- Uses a valid/ready handshake on the parallel side and a shift-enable on the serial side.
- Back-to-back words stream with no idle bubble.
- Feeds the serial link / bit-level consumer of the datapath.

Parameters:
- WIDTH, 4, parallel word width in bits (>= 2)
- MSB_FIRST, 0, 0 = bit 0 shifted first; 1 = bit WIDTH-1 shifted first

Ports:
- clk  input  1  clock; all state updates on posedge clk
- rst  input  1  synchronous, active-high reset
- i  input  WIDTH  parallel word from the PIPO register stage
- in_valid  input  1  i holds a word to transfer
- in_ready  output  1  serializer accepts i this cycle
- shift_en  input  1  serial consumer takes the current bit this cycle
- ser_out  output  1  current serial bit
- ser_valid  output  1  ser_out is meaningful
- ser_first  output  1  current bit is the first bit of a frame
- ser_last  output  1  current bit is the last bit of a frame

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. While rst is sampled high at a posedge:
  - state goes to IDLE; shift register and bit counter clear to 0.
  - ser_out, ser_valid, ser_first and ser_last are registered and read 0 after that edge.
- in_ready is combinational and forced 0 while rst = 1.
- FSM states:
  - IDLE: ser_valid = 0.
  - SHIFT: ser_valid = 1.
  - PARITY: exists only with the optional feature.
- Accept: a transfer occurs at a posedge with in_valid & in_ready.
  - in_ready = (state == IDLE) | (state == SHIFT/PARITY on its final bit with shift_en = 1).
- Latency: word accepted at edge N. From edge N+1:
  - ser_valid = 1, ser_first = 1, ser_out = first bit (i[0], or i[WIDTH-1] if MSB_FIRST).
- Advance: each posedge with shift_en = 1 in SHIFT consumes the current bit.
  - Bit counter increments; counter width is $clog2(WIDTH).
  - The next bit is presented; ser_first drops to 0.
- Hold: with shift_en = 0, ser_out, ser_first, ser_last and the counter hold indefinitely. in_valid is ignored unless in_ready.
- ser_last = 1 while the final bit of the frame is presented (counter == WIDTH-1 without the feature).
- Final-bit consumption:
  - With a simultaneous accept, go directly to SHIFT with the new word, counter 0 and ser_first = 1 (zero-bubble streaming).
  - Otherwise go to IDLE; ser_valid drops to 0 on the following cycle.
- Input capture: i is sampled only at the accept edge. Later changes to i do not affect the frame in flight.
- Reset mid-frame: the frame is abandoned, no further bits are emitted, and the FSM returns to IDLE on the next edge.
- No X propagation: ser_out = 0 whenever ser_valid = 0.

Optional Feature:
- Macro: PISO_SERIALIZER_PARITY_EN
- Defined:
  - After the WIDTH data bits, state PARITY presents one extra even-parity bit, the XOR of the captured word.
  - ser_last is asserted on the parity bit, not on the last data bit.
  - Frame length is WIDTH+1 enabled cycles; the zero-bubble accept rule applies at the parity bit.
  - A parity register captures the XOR at accept.
- Undefined: PARITY state and parity register are absent; frame length is WIDTH bits.

Decomposition:
- Shared package piso_pkg holds:
  - state enum typedef (IDLE, SHIFT, PARITY)
  - localparam CNT_W = $clog2(WIDTH)
  - frame-length function WIDTH + parity bit
- One natural sub-module: piso_shreg, a loadable shift register with direction select (MSB_FIRST) and enable. FSM and counter stay in the top.

Test Plan:
- rst = 1 for 2 cycles, then 0 with in_valid = 0 -> in_ready = 0 during reset, 1 after; ser_valid = 0, ser_out = 0.
- i = 4'b1011, in_valid pulse, shift_en = 1 constantly, MSB_FIRST = 0 -> ser_out sequence 1,1,0,1 on cycles N+1..N+4; ser_first on the first bit, ser_last on the 4th; ser_valid = 0 at N+5.
- Back-to-back: 4'b0011 then 4'b1100, in_valid held -> 8 contiguous valid bits 1,1,0,0,0,0,1,1; ser_first at bits 1 and 5; no gap.
- shift_en low for 3 cycles after bit 2 of 4'b0110 -> ser_out = 1 held for 4 cycles, counter unchanged, frame resumes 1,0.
- rst asserted at bit 3 of a frame -> ser_valid = 0 after that edge; the next accepted word 4'b1111 starts with ser_first = 1.
- With PISO_SERIALIZER_PARITY_EN, i = 4'b0111 -> bits 1,1,1,0 then parity 1 with ser_last; i = 4'b0101 -> parity 0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   state_t     FSM state encoding (IDLE, SHIFT, PARITY)
//   PAR_BITS    number of trailing parity bits per frame (0 or 1)
//   cnt_width() bit-counter width for a given word width ($clog2(WIDTH))
//   frame_len() enabled cycles per frame: data bits plus parity bit
// Optional feature macro: PISO_SERIALIZER_PARITY_EN adds the parity bit.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    // Counter only walks the data bits, so it needs $clog2(WIDTH) bits.
    // The floor of 1 keeps the vector legal for degenerate widths.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int frame_len(input int width);
        return width + PAR_BITS;
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// Loadable shift register feeding the serializer's output bit register.
// Latency: load or shift takes effect at the next posedge clk.
// Backpressure: none; the owner gates 'shift' with the serial enable.
//
// Ports:
//   clk, rst  clock and synchronous active-high reset (clears contents)
//   load      capture d (takes priority over shift)
//   shift     advance by one bit toward the output end, zero fill
//   d         parallel word to load
//   peek      bit that becomes the head after the next shift
module piso_shreg #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             peek
);

    logic [WIDTH-1:0] q;

    // Head of the register is q[0] for LSB-first and q[WIDTH-1] for
    // MSB-first. Zero fill means a fully drained register reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            if (MSB_FIRST) begin
                q <= {q[WIDTH-2:0], 1'b0};
            end else begin
                q <= {1'b0, q[WIDTH-1:1]};
            end
        end
    end

    // The caller registers its output bit at the same edge the shift
    // happens, so it needs the bit one position behind the head.
    assign peek = MSB_FIRST ? q[WIDTH-2] : q[1];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: one bit per enabled cycle, zero-bubble streaming.
// Latency: word accepted at edge N is presented on ser_out from edge N+1.
// Backpressure: shift_en=0 holds the current bit; in_ready only in IDLE or on final-bit consume.
//
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   i          parallel word (sampled only at the accept edge)
//   in_valid   i holds a word
//   in_ready   combinational; accept when in_valid & in_ready at posedge
//   shift_en   serial consumer takes the current bit this cycle
//   ser_out    current serial bit (0 whenever ser_valid = 0)
//   ser_valid  ser_out is meaningful
//   ser_first  first bit of a frame
//   ser_last   last bit of a frame
// Optional feature macro: PISO_SERIALIZER_PARITY_EN appends an even-parity
// bit (XOR of the word) after the data bits; ser_last then marks it.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last
);

    localparam int              CW          = cnt_width(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST    = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   CNT_PRELAST = CW'(WIDTH - 2);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           last_data;
    logic           final_bit;
    logic           accept;
    logic           first_bit;
    logic           sr_shift;
    logic           sr_peek;

`ifdef PISO_SERIALIZER_PARITY_EN
    logic           par;
`endif

    assign last_data = (state == SHIFT) && (cnt == CNT_LAST);

`ifdef PISO_SERIALIZER_PARITY_EN
    assign final_bit = (state == PARITY);
`else
    assign final_bit = last_data;
`endif

    // Ready while idle, or when the bit being consumed this edge ends the
    // frame: that is what lets the next word follow with no bubble.
    assign in_ready  = !rst && ((state == IDLE) || (final_bit && shift_en));
    assign accept    = in_valid && in_ready;
    assign first_bit = MSB_FIRST ? i[WIDTH-1] : i[0];

    // The final data bit never needs shifting out: the next thing shown is
    // either a new word, the parity bit, or nothing.
    assign sr_shift  = (state == SHIFT) && shift_en && !last_data;

    piso_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (sr_shift),
        .d     (i),
        .peek  (sr_peek)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_first <= 1'b0;
            ser_last  <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            par       <= 1'b0;
`endif
        end else if (accept) begin
            // Covers both a start from IDLE and a back-to-back restart.
            state     <= SHIFT;
            cnt       <= '0;
            ser_out   <= first_bit;
            ser_valid <= 1'b1;
            ser_first <= 1'b1;
            ser_last  <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            par       <= ^i;
`endif
        end else if ((state == SHIFT) && shift_en) begin
            ser_first <= 1'b0;
            if (!last_data) begin
                cnt     <= cnt + 1'b1;
                ser_out <= sr_peek;
`ifdef PISO_SERIALIZER_PARITY_EN
                ser_last <= 1'b0;
`else
                ser_last <= (cnt == CNT_PRELAST);
`endif
            end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
                state    <= PARITY;
                cnt      <= '0;
                ser_out  <= par;
                ser_last <= 1'b1;
`else
                state     <= IDLE;
                cnt       <= '0;
                ser_out   <= 1'b0;
                ser_valid <= 1'b0;
                ser_last  <= 1'b0;
`endif
            end
`ifdef PISO_SERIALIZER_PARITY_EN
        end else if ((state == PARITY) && shift_en) begin
            state     <= IDLE;
            cnt       <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_first <= 1'b0;
            ser_last  <= 1'b0;
`endif
        end
    end

endmodule
